rpn_sequencer: RTL and testbench

RPN_SEQUENCER -- requirements
Module: rpn_sequencer

---
 rtl/rpn_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_rpn_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_sequencer.sv
// Token-driven RPN expression sequencer: buffers tokens in a FIFO and expands
// each one into two-cycle stack micro-commands, collecting the final result.
//
// state  | meaning
// IDLE   | waiting for a buffered token
// FETCH  | pop token, run pre-checks, latch micro-sequence
// CMD    | drive current micro-command to the stack
// CHK    | sample stack response, advance or finish
// DONE   | present result for one cycle
// ERROR  | sticky fault, FIFO flushed, waits for rst
module rpn_sequencer #(
  parameter int N          = 4,
  parameter int MAX_SIZE   = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         token_valid,
  input  logic [N+1:0] token_data,
  output logic         token_ready,
  output logic [2:0]   stk_opcode,
  output logic [N-1:0] stk_input_data,
  input  logic [N-1:0] stk_output_data,
  input  logic         stk_overflow,
  input  logic         stk_success,
  output logic [N-1:0] result,
  output logic         result_valid,
  output logic         result_overflow,
  output logic         error,
  output logic         busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(MAX_SIZE + 1);

  localparam logic [1:0] K_PUSH = 2'b00;
  localparam logic [1:0] K_ADD  = 2'b01;
  localparam logic [1:0] K_MUL  = 2'b10;
  localparam logic [1:0] K_END  = 2'b11;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CMD,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t r_state, w_next_state;

  logic [N+1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [1:0]    r_kind;
  logic [N-1:0]  r_value;
  logic [N-1:0]  r_capt;
  logic [1:0]    r_step;
  logic [DW-1:0] r_depth;
  logic          r_sticky;
  logic [N-1:0]  r_result;

  logic          w_full, w_empty, w_push, w_pop, w_flush;
  logic [N+1:0]  w_head;
  logic [1:0]    w_head_kind;
  logic          w_head_alu, w_cur_alu;
  logic          w_precheck_fail;
  logic          w_last_step;
  logic [2:0]    w_step_op;
  logic [N-1:0]  w_step_data;
  logic [2:0]    w_opcode;
  logic [N-1:0]  w_data;

  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_flush     = (r_state == S_ERROR);
  assign token_ready = !w_full && (r_state != S_ERROR);
  assign w_push      = token_valid && token_ready;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_kind = w_head[N+1:N];
  assign w_head_alu  = (w_head_kind == K_ADD) || (w_head_kind == K_MUL);
  assign w_cur_alu   = (r_kind == K_ADD) || (r_kind == K_MUL);

  always_comb begin
    w_precheck_fail = 1'b0;
    case (w_head_kind)
      K_PUSH:  w_precheck_fail = (r_depth == DW'(MAX_SIZE));
      K_END:   w_precheck_fail = (r_depth != DW'(1));
      default: w_precheck_fail = (r_depth < DW'(2));
    endcase
  end

  // ALU tokens expand to: ALU, pop, pop, push of the captured ALU result.
  always_comb begin
    w_step_op   = OP_PUSH;
    w_step_data = '0;
    w_last_step = 1'b1;
    case (r_kind)
      K_PUSH: begin
        w_step_op   = OP_PUSH;
        w_step_data = r_value;
      end
      K_END: w_step_op = OP_POP;
      default: begin
        w_last_step = (r_step == 2'd3);
        case (r_step)
          2'd0:    w_step_op = (r_kind == K_ADD) ? OP_ADD : OP_MUL;
          2'd1,
          2'd2:    w_step_op = OP_POP;
          default: begin
            w_step_op   = OP_PUSH;
            w_step_data = r_capt;
          end
        endcase
      end
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_opcode     = OP_NOP;
    w_data       = '0;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next_state = S_FETCH;
      S_FETCH: begin
        if (w_precheck_fail) begin
          w_next_state = S_ERROR;
        end else begin
          w_pop        = 1'b1;
          w_next_state = S_CMD;
        end
      end
      S_CMD: begin
        w_opcode     = w_step_op;
        w_data       = w_step_data;
        w_next_state = S_CHK;
      end
      S_CHK: begin
        if (!stk_success)          w_next_state = S_ERROR;
        else if (!w_last_step)     w_next_state = S_CMD;
        else if (r_kind == K_END)  w_next_state = S_DONE;
        else if (!w_empty)         w_next_state = S_FETCH;
        else                       w_next_state = S_IDLE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= token_data;
  end

  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_kind   <= K_PUSH;
      r_value  <= '0;
      r_capt   <= '0;
      r_step   <= '0;
      r_depth  <= '0;
      r_sticky <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_FETCH: begin
          if (!w_precheck_fail) begin
            r_kind  <= w_head_kind;
            r_value <= w_head[N-1:0];
            r_step  <= '0;
            if (w_head_kind == K_PUSH) r_depth <= r_depth + DW'(1);
            else if (w_head_alu || w_head_kind == K_END) r_depth <= r_depth - DW'(1);
          end
        end
        S_CHK: begin
          r_step <= r_step + 2'd1;
          if (stk_success) begin
            if (w_cur_alu && r_step == 2'd0) begin
              r_capt   <= stk_output_data;
              r_sticky <= r_sticky | stk_overflow;
            end
            if (r_kind == K_END) r_result <= stk_output_data;
          end
        end
        S_DONE: begin
          r_depth  <= '0;
          r_sticky <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign stk_opcode      = w_opcode;
  assign stk_input_data  = w_data;
  assign result          = r_result;
  assign result_valid    = (r_state == S_DONE);
  assign result_overflow = (r_state == S_DONE) && r_sticky;
  assign error           = (r_state == S_ERROR);
  assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_rpn_sequencer.sv
// Directed bench for rpn_sequencer with a behavioural stack partner and
// hand-computed expectations (N = 4, so values wrap at -8..7).
module tb_rpn_sequencer;

  localparam int N = 4;

  localparam logic [1:0] K_PUSH = 2'b00;
  localparam logic [1:0] K_ADD  = 2'b01;
  localparam logic [1:0] K_MUL  = 2'b10;
  localparam logic [1:0] K_END  = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         token_valid = 1'b0;
  logic [N+1:0] token_data = '0;
  logic         token_ready;
  logic [2:0]   stk_opcode;
  logic [N-1:0] stk_input_data;
  logic [N-1:0] stk_output_data;
  logic         stk_overflow;
  logic         stk_success;
  logic [N-1:0] result;
  logic         result_valid;
  logic         result_overflow;
  logic         error;
  logic         busy;

  rpn_sequencer #(.N(N), .MAX_SIZE(1024), .FIFO_DEPTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .token_valid     (token_valid),
    .token_data      (token_data),
    .token_ready     (token_ready),
    .stk_opcode      (stk_opcode),
    .stk_input_data  (stk_input_data),
    .stk_output_data (stk_output_data),
    .stk_overflow    (stk_overflow),
    .stk_success     (stk_success),
    .result          (result),
    .result_valid    (result_valid),
    .result_overflow (result_overflow),
    .error           (error),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Behavioural stack: executes the command seen at the edge, responds next cycle.
  logic signed [N-1:0] smem [64];
  int   sp;
  logic force_fail = 1'b0;

  always @(posedge clk) begin
    int a, b, full;
    if (rst) begin
      sp              <= 0;
      stk_success     <= 1'b0;
      stk_output_data <= '0;
      stk_overflow    <= 1'b0;
    end else begin
      case (stk_opcode)
        3'b110: begin
          if (force_fail || sp >= 64) stk_success <= 1'b0;
          else begin
            smem[sp]        <= stk_input_data;
            sp              <= sp + 1;
            stk_success     <= 1'b1;
            stk_output_data <= stk_input_data;
            stk_overflow    <= 1'b0;
          end
        end
        3'b111: begin
          if (force_fail || sp < 1) stk_success <= 1'b0;
          else begin
            stk_output_data <= smem[sp-1];
            sp              <= sp - 1;
            stk_success     <= 1'b1;
            stk_overflow    <= 1'b0;
          end
        end
        3'b100, 3'b101: begin
          if (force_fail || sp < 2) stk_success <= 1'b0;
          else begin
            a = int'(smem[sp-1]);
            b = int'(smem[sp-2]);
            full = (stk_opcode == 3'b100) ? a + b : a * b;
            stk_output_data <= full[N-1:0];
            stk_overflow    <= (full > 7) || (full < -8);
            stk_success     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  logic [2:0]   op_log[$];
  int           pulse_cnt = 0;
  logic [N-1:0] last_res = '0;
  logic         last_ovf = 1'b0;

  always @(negedge clk) begin
    if (!rst && stk_opcode != 3'b000) op_log.push_back(stk_opcode);
    if (result_valid) begin
      pulse_cnt <= pulse_cnt + 1;
      last_res  <= result;
      last_ovf  <= result_overflow;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] k, input logic [N-1:0] v, output int stall);
    stall       = 0;
    token_valid = 1'b1;
    token_data  = {k, v};
    while (!token_ready && stall < 200) begin
      tick();
      stall++;
    end
    check("send_ready", 32'(token_ready), 32'd1);
    tick();
    token_valid = 1'b0;
  endtask

  task automatic wait_pulse(input int target);
    for (int i = 0; i < 300 && pulse_cnt < target; i++) tick();
    check("pulse_timeout", 32'(pulse_cnt >= target), 32'd1);
  endtask

  task automatic wait_idle();
    int quiet;
    quiet = 0;
    for (int i = 0; i < 300 && quiet < 2; i++) begin
      tick();
      quiet = busy ? 0 : quiet + 1;
    end
    check("idle_timeout", 32'(quiet), 32'd2);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    force_fail = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] exp036 [7];
    int st, p0, n100;
    exp036 = '{3'b110, 3'b110, 3'b100, 3'b111, 3'b111, 3'b110, 3'b111};

    do_reset();
    check("rst_opcode", 32'(stk_opcode), 32'd0);
    check("rst_data", 32'(stk_input_data), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_rvalid", 32'(result_valid), 32'd0);
    check("rst_rovf", 32'(result_overflow), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(token_ready), 32'd1);

    // 3 + 2
    op_log.delete();
    p0 = pulse_cnt;
    send(K_PUSH, 4'd3, st);
    send(K_PUSH, 4'd2, st);
    send(K_ADD, 4'd0, st);
    send(K_END, 4'd0, st);
    wait_pulse(p0 + 1);
    wait_idle();
    check("t1_result", 32'(last_res), 32'd5);
    check("t1_ovf", 32'(last_ovf), 32'd0);
    check("t1_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("t1_nops", 32'(op_log.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      check($sformatf("t1_op%0d", i), 32'(op_log[i]), 32'(exp036[i]));

    // 7 + 1 wraps to -8
    p0 = pulse_cnt;
    send(K_PUSH, 4'd7, st);
    send(K_PUSH, 4'd1, st);
    send(K_ADD, 4'd0, st);
    send(K_END, 4'd0, st);
    wait_pulse(p0 + 1);
    wait_idle();
    check("t2_result", 32'(last_res), 32'h8);
    check("t2_ovf", 32'(last_ovf), 32'd1);

    // 3 * -2 = -6, sticky overflow must have been cleared
    p0 = pulse_cnt;
    send(K_PUSH, 4'd3, st);
    send(K_PUSH, 4'hE, st);
    send(K_MUL, 4'd0, st);
    send(K_END, 4'd0, st);
    wait_pulse(p0 + 1);
    wait_idle();
    check("t3_result", 32'(last_res), 32'hA);
    check("t3_ovf", 32'(last_ovf), 32'd0);

    // FIFO fill while an add occupies the FSM: 2*3=6, 6-4=2, 2*3=6, 6+1=7
    op_log.delete();
    p0 = pulse_cnt;
    send(K_PUSH, 4'd1, st);
    send(K_PUSH, 4'd1, st);
    wait_idle();
    send(K_ADD, 4'd0, st);
    send(K_PUSH, 4'd3, st);
    send(K_MUL, 4'd0, st);
    send(K_PUSH, 4'hC, st);
    send(K_ADD, 4'd0, st);
    send(K_PUSH, 4'd3, st);
    send(K_MUL, 4'd0, st);
    send(K_PUSH, 4'd1, st);
    send(K_ADD, 4'd0, st);
    check("t4_full_ready", 32'(token_ready), 32'd0);
    send(K_END, 4'd0, st);
    check("t4_stall", 32'(st), 32'd3);
    wait_pulse(p0 + 1);
    wait_idle();
    check("t4_result", 32'(last_res), 32'd7);
    check("t4_ovf", 32'(last_ovf), 32'd0);
    check("t4_nops", 32'(op_log.size()), 32'd27);

    // reset during the pop step of an add
    send(K_PUSH, 4'd4, st);
    send(K_PUSH, 4'd1, st);
    send(K_ADD, 4'd0, st);
    for (int i = 0; i < 50 && stk_opcode != 3'b111; i++) tick();
    check("t5_popseen", 32'(stk_opcode), 32'h7);
    rst = 1'b1;
    tick();
    check("t5_opcode", 32'(stk_opcode), 32'd0);
    check("t5_data", 32'(stk_input_data), 32'd0);
    check("t5_result", 32'(result), 32'd0);
    check("t5_rvalid", 32'(result_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_error", 32'(error), 32'd0);
    check("t5_ready", 32'(token_ready), 32'd1);
    rst = 1'b0;
    tick();
    tick();
    tick();
    check("t5_fifo_empty", 32'(busy), 32'd0);

    // add with a single operand: error, no ALU command
    op_log.delete();
    send(K_PUSH, 4'd5, st);
    send(K_ADD, 4'd0, st);
    repeat (12) tick();
    n100 = 0;
    foreach (op_log[i]) if (op_log[i] == 3'b100) n100++;
    check("t6_error", 32'(error), 32'd1);
    check("t6_no_add", 32'(n100), 32'd0);
    check("t6_nops", 32'(op_log.size()), 32'd1);
    check("t6_ready", 32'(token_ready), 32'd0);
    check("t6_opcode", 32'(stk_opcode), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
    do_reset();
    check("t6_error_clr", 32'(error), 32'd0);

    // end on an empty stack
    op_log.delete();
    send(K_END, 4'd0, st);
    repeat (8) tick();
    check("t7_error", 32'(error), 32'd1);
    check("t7_nops", 32'(op_log.size()), 32'd0);
    do_reset();

    // stack refuses a push
    force_fail = 1'b1;
    send(K_PUSH, 4'd1, st);
    repeat (8) tick();
    check("t8_error", 32'(error), 32'd1);
    do_reset();
    check("t8_error_clr", 32'(error), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
